// File: rtl/buffered_transceiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : buffered_transceiver_pkg
//  Description : Shared definitions for the buffered LED/photodiode
//                transceiver: payload size, line levels, FSM encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package buffered_transceiver_pkg;

    // Payload bits carried by one line frame
    localparam int PACKET_SIZE = 8;

    // Line levels: idle and stop share the dark level so an idle line
    // never looks like a start bit.
    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;
    localparam logic LINE_STOP  = 1'b0;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/buffered_transceiver_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : buffered_transceiver_sync_fifo
//  Description : Single-clock first-word-fall-through FIFO with full/empty
//                flags. A push into a full FIFO is accepted when a pop
//                happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module buffered_transceiver_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int                c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_depth  = (c_addr_w + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                w_pop_ok;
    logic                w_push_ok;

    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);

    // Storage array: written on accepted pushes, no reset needed
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/buffered_transceiver.sv
`default_nettype none
// ============================================================================
//  Module      : buffered_transceiver
//  Description : Full-duplex serial transceiver for the LED/photodiode link.
//                TX FIFO -> framer -> led; signal -> 2-FF sync -> deframer
//                -> RX FIFO. Frame: start, data LSB first, optional even
//                parity, stop; every bit held BIT_CYCLES clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module buffered_transceiver
    import buffered_transceiver_pkg::*;
#(
    parameter int DATA_WIDTH = PACKET_SIZE,
    parameter int BIT_CYCLES = 16,
    parameter int TX_DEPTH   = 4,
    parameter int RX_DEPTH   = 4,
    parameter int PARITY_EN  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tx_enable,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  led,
    input  logic                  signal,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  irq_tx,
    output logic                  irq_rx,
    output logic                  err_parity,
    output logic                  err_frame,
    output logic                  err_overflow,
    input  logic                  err_clear
);

    localparam int c_cyc_w = $clog2(BIT_CYCLES);
    localparam int c_bit_w = $clog2(DATA_WIDTH + 1);
    localparam logic [c_cyc_w-1:0] c_cyc_last  = c_cyc_w'(BIT_CYCLES - 1);
    localparam logic [c_cyc_w-1:0] c_half_last = c_cyc_w'(BIT_CYCLES / 2 - 1);
    localparam logic [c_bit_w-1:0] c_bit_last  = c_bit_w'(DATA_WIDTH - 1);

    if ((BIT_CYCLES % 2) != 0 || BIT_CYCLES < 4) begin : g_bad_bit_cycles
        $error("BIT_CYCLES must be even and at least 4");
    end

    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
        $error("PARITY_EN must be 0 or 1");
    end

    // ------------------------------------------------------------------
    // TX side
    // ------------------------------------------------------------------
    tx_state_t             r_tx_state;
    logic [c_cyc_w-1:0]    r_tx_cyc;
    logic [c_bit_w-1:0]    r_tx_bit;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic                  r_tx_par;
    logic                  r_led;
    logic                  r_irq_tx;
    logic [DATA_WIDTH-1:0] w_tx_head;
    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic                  w_tx_push;
    logic                  w_tx_pop;
    logic                  w_tx_bit_end;

    assign tx_ready     = ~w_tx_full;
    assign w_tx_push    = tx_valid & ~w_tx_full;
    assign w_tx_pop     = (r_tx_state == TX_IDLE) & tx_enable & ~w_tx_empty;
    assign w_tx_bit_end = (r_tx_cyc == c_cyc_last);
    assign led          = r_led;
    assign irq_tx       = r_irq_tx;

    buffered_transceiver_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .i_push  (w_tx_push),
        .i_data  (tx_data),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    // Framer: walks the frame one bit per BIT_CYCLES clocks, led registered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cyc   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_led      <= LINE_IDLE;
            r_irq_tx   <= 1'b0;
        end else begin
            r_irq_tx <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_cyc <= '0;
                    r_tx_bit <= '0;
                    if (w_tx_pop) begin
                        r_tx_shift <= w_tx_head;
                        r_tx_par   <= ^w_tx_head;
                        r_tx_state <= TX_START;
                        r_led      <= LINE_START;
                    end
                end
                TX_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_cyc   <= '0;
                        r_tx_state <= TX_DATA;
                        r_led      <= r_tx_shift[0];
                    end else begin
                        r_tx_cyc <= r_tx_cyc + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_tx_bit_end) begin
                        r_tx_cyc <= '0;
                        if (r_tx_bit == c_bit_last) begin
                            r_tx_bit <= '0;
                            if (PARITY_EN != 0) begin
                                r_tx_state <= TX_PARITY;
                                r_led      <= r_tx_par;
                            end else begin
                                r_tx_state <= TX_STOP;
                                r_led      <= LINE_STOP;
                            end
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_led      <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cyc <= r_tx_cyc + 1'b1;
                    end
                end
                TX_PARITY: begin
                    if (w_tx_bit_end) begin
                        r_tx_cyc   <= '0;
                        r_tx_state <= TX_STOP;
                        r_led      <= LINE_STOP;
                    end else begin
                        r_tx_cyc <= r_tx_cyc + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (w_tx_bit_end) begin
                        r_tx_cyc   <= '0;
                        r_tx_state <= TX_IDLE;
                        r_led      <= LINE_IDLE;
                        // Interrupt only when nothing is left or arriving to send
                        r_irq_tx   <= w_tx_empty & ~w_tx_push;
                    end else begin
                        r_tx_cyc <= r_tx_cyc + 1'b1;
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_led      <= LINE_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX side
    // ------------------------------------------------------------------
    rx_state_t             r_rx_state;
    logic [c_cyc_w-1:0]    r_rx_cyc;
    logic [c_bit_w-1:0]    r_rx_bit;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic                  r_rx_par;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_rx_prev;
    logic                  r_err_parity;
    logic                  r_err_frame;
    logic                  r_err_overflow;
    logic                  w_rx_full;
    logic                  w_rx_empty;
    logic                  w_rx_pop;
    logic                  w_rx_push;
    logic                  w_rx_bit_end;
    logic                  w_rx_stop_done;
    logic                  w_stop_bad;
    logic                  w_par_bad;
    logic                  w_ovf;

    assign w_rx_bit_end   = (r_rx_cyc == c_cyc_last);
    assign w_rx_stop_done = (r_rx_state == RX_STOP) & w_rx_bit_end;
    assign w_rx_pop       = rx_ready & ~w_rx_empty;
    // Checks are prioritised: stop bit, then parity, then room in the FIFO
    assign w_stop_bad     = w_rx_stop_done & (r_sync2 != LINE_STOP);
    assign w_par_bad      = w_rx_stop_done & ~w_stop_bad & (PARITY_EN != 0)
                            & ((^r_rx_shift) != r_rx_par);
    assign w_ovf          = w_rx_stop_done & ~w_stop_bad & ~w_par_bad
                            & w_rx_full & ~w_rx_pop;
    assign w_rx_push      = w_rx_stop_done & ~w_stop_bad & ~w_par_bad & ~w_ovf;

    assign rx_valid     = ~w_rx_empty;
    assign irq_rx       = ~w_rx_empty;
    assign err_parity   = r_err_parity;
    assign err_frame    = r_err_frame;
    assign err_overflow = r_err_overflow;

    buffered_transceiver_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .i_push  (w_rx_push),
        .i_data  (r_rx_shift),
        .i_pop   (w_rx_pop),
        .o_data  (rx_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    // Two-stage synchroniser plus a delayed copy for start-edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1   <= LINE_IDLE;
            r_sync2   <= LINE_IDLE;
            r_rx_prev <= LINE_IDLE;
        end else begin
            r_sync1   <= signal;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Deframer: confirm the start bit at its middle, then sample mid-bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_cyc   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cyc <= '0;
                    r_rx_bit <= '0;
                    if (r_sync2 == LINE_START && r_rx_prev != LINE_START) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cyc == c_half_last) begin
                        r_rx_cyc   <= '0;
                        // A start bit that has already gone away was a glitch
                        r_rx_state <= (r_sync2 == LINE_START) ? RX_DATA : RX_IDLE;
                    end else begin
                        r_rx_cyc <= r_rx_cyc + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_cyc   <= '0;
                        r_rx_shift <= {r_sync2, r_rx_shift[DATA_WIDTH-1:1]};
                        if (r_rx_bit == c_bit_last) begin
                            r_rx_bit   <= '0;
                            r_rx_state <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end else begin
                        r_rx_cyc <= r_rx_cyc + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (w_rx_bit_end) begin
                        r_rx_cyc   <= '0;
                        r_rx_par   <= r_sync2;
                        r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cyc <= r_rx_cyc + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_bit_end) begin
                        r_rx_cyc   <= '0;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_cyc <= r_rx_cyc + 1'b1;
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle survives
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err_parity   <= 1'b0;
            r_err_frame    <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_err_parity   <= (r_err_parity   & ~err_clear) | w_par_bad;
            r_err_frame    <= (r_err_frame    & ~err_clear) | w_stop_bad;
            r_err_overflow <= (r_err_overflow & ~err_clear) | w_ovf;
        end
    end

endmodule
`default_nettype wire
